freeze_rom_loader: RTL



---
 rtl/freeze_pkg.sv | 41 ++++
 rtl/freeze_rom_loader_if.sv | 39 +++
 rtl/freeze_rom_region_dec.sv | 41 ++++
 rtl/freeze_rom_loader.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/freeze_pkg.sv
// freeze_pkg
// Shared definitions for the Freeze ROM download front-end: region indices,
// loader FSM states, bus widths and the region base / image size calculation.
package freeze_pkg;

    localparam int NUM_REGIONS = 5;
    localparam int REG_MROM1   = 0;
    localparam int REG_MROM2   = 1;
    localparam int REG_SROM    = 2;
    localparam int REG_CHAR    = 3;
    localparam int REG_SPR     = 4;

    localparam int ADDR_W      = 27;   // ioctl byte address width
    localparam int ROM_ADDR_W  = 16;   // region-relative byte address width
    localparam int CNT_W       = 17;   // loaded byte counter width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_t;

    // Base byte address of region k = sum of the sizes of regions 0..k-1.
    // k = NUM_REGIONS yields the full image size.
    function automatic logic [ADDR_W-1:0] region_base(input int k,
                                                      input int s0, input int s1,
                                                      input int s2, input int s3,
                                                      input int s4);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        if (k > 0) acc = acc + ADDR_W'(s0);
        if (k > 1) acc = acc + ADDR_W'(s1);
        if (k > 2) acc = acc + ADDR_W'(s2);
        if (k > 3) acc = acc + ADDR_W'(s3);
        if (k > 4) acc = acc + ADDR_W'(s4);
        return acc;
    endfunction

endpackage

// File: rtl/freeze_rom_loader_if.sv
// freeze_rom_loader_if
// Bundles the HPS ioctl download stream and the ROM write port of the loader.
//   master : HPS / test side (drives ioctl_*, observes rom_* and status)
//   slave  : loader side     (consumes ioctl_*, drives rom_* and status)
// Signals:
//   ioctl_download  download window active
//   ioctl_addr      byte address of the current 16-bit word
//   ioctl_dout      data word, [7:0] -> addr, [15:8] -> addr+1
//   ioctl_wr        single-cycle word strobe
//   ioctl_wait      stall request back to the HPS
//   rom_we          one-hot byte write enable per region
//   rom_addr        region-relative byte address
//   rom_data        byte to write
//   core_reset      active-high reset for the game logic
//   load_err        sticky download error flag
interface freeze_rom_loader_if;

    logic                                ioctl_download;
    logic [freeze_pkg::ADDR_W-1:0]       ioctl_addr;
    logic [15:0]                         ioctl_dout;
    logic                                ioctl_wr;
    logic                                ioctl_wait;
    logic [freeze_pkg::NUM_REGIONS-1:0]  rom_we;
    logic [freeze_pkg::ROM_ADDR_W-1:0]   rom_addr;
    logic [7:0]                          rom_data;
    logic                                core_reset;
    logic                                load_err;

    modport master (
        output ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
        input  ioctl_wait, rom_we, rom_addr, rom_data, core_reset, load_err
    );

    modport slave (
        input  ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
        output ioctl_wait, rom_we, rom_addr, rom_data, core_reset, load_err
    );

endinterface

// File: rtl/freeze_rom_region_dec.sv
// freeze_rom_region_dec
// Combinational decode of a flat image byte address into its ROM region.
// Ports:
//   i_addr    flat byte address within the download image
//   o_region  one-hot region select (bit k = region k)
//   o_offset  byte address relative to the region base, truncated to 16 bits
//   o_oor     address lies at or beyond the end of the image
module freeze_rom_region_dec
    import freeze_pkg::*;
#(
    parameter int MROM1_SIZE = 32768,
    parameter int MROM2_SIZE = 16384,
    parameter int SROM_SIZE  = 8192,
    parameter int CHAR_SIZE  = 16384,
    parameter int SPR_SIZE   = 16384
)
(
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [NUM_REGIONS-1:0] o_region,
    output logic [ROM_ADDR_W-1:0]  o_offset,
    output logic                   o_oor
);

    logic [ADDR_W-1:0] w_base;

    always_comb begin
        o_region = '0;
        o_oor    = 1'b1;
        w_base   = '0;
        for (int k = 0; k < NUM_REGIONS; k++) begin
            if ((i_addr >= region_base(k, MROM1_SIZE, MROM2_SIZE, SROM_SIZE, CHAR_SIZE, SPR_SIZE)) &&
                (i_addr <  region_base(k + 1, MROM1_SIZE, MROM2_SIZE, SROM_SIZE, CHAR_SIZE, SPR_SIZE))) begin
                o_region[k] = 1'b1;
                o_oor       = 1'b0;
                w_base      = region_base(k, MROM1_SIZE, MROM2_SIZE, SROM_SIZE, CHAR_SIZE, SPR_SIZE);
            end
        end
        o_offset = ROM_ADDR_W'(i_addr - w_base);
    end

endmodule

// File: rtl/freeze_rom_loader.sv
// freeze_rom_loader
// Download front-end for the Freeze core. Splits each 16-bit ioctl word into
// two byte writes, routes each byte to one of five ROM regions, counts the
// bytes loaded and keeps the core in reset until a complete, error-free image
// of exactly the expected size has arrived.
// Ports:
//   clk_sys  system clock
//   rst_n    asynchronous active-low reset
//   bus      freeze_rom_loader_if.slave (ioctl stream in, ROM writes/status out)
module freeze_rom_loader
    import freeze_pkg::*;
#(
    parameter int MROM1_SIZE = 32768,
    parameter int MROM2_SIZE = 16384,
    parameter int SROM_SIZE  = 8192,
    parameter int CHAR_SIZE  = 16384,
    parameter int SPR_SIZE   = 16384
)
(
    input  logic               clk_sys,
    input  logic               rst_n,
    freeze_rom_loader_if.slave bus
);

    localparam logic [ADDR_W-1:0] TOTAL =
        region_base(NUM_REGIONS, MROM1_SIZE, MROM2_SIZE, SROM_SIZE, CHAR_SIZE, SPR_SIZE);
    localparam logic [CNT_W-1:0]  TOTAL_CNT = CNT_W'(TOTAL);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_dl_q;

    logic                    r_buf_vld_p0;
    logic                    r_buf_hi_p0;     // buffered word has only its HI byte left
    logic [ADDR_W-2:0]       r_buf_addr_p0;   // word address, byte-select bit dropped
    logic [15:0]             r_buf_data_p0;

    logic [NUM_REGIONS-1:0]  r_rom_we_p1;
    logic [ROM_ADDR_W-1:0]   r_rom_addr_p1;
    logic [7:0]              r_rom_data_p1;

    logic [CNT_W-1:0]        r_byte_cnt;
    logic                    r_load_err;

    logic                    w_dl_rise;
    logic                    w_strobe;
    logic                    w_accept;
    logic                    w_drop;
    logic                    w_emit;
    logic [ADDR_W-1:0]       w_emit_addr;
    logic [7:0]              w_emit_data;
    logic [NUM_REGIONS-1:0]  w_region;
    logic [ROM_ADDR_W-1:0]   w_offset;
    logic                    w_oor;
    logic                    w_wr_ok;
    logic                    w_enter_load;
    logic                    w_check_fail;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_err_nxt;

    // Odd addresses are treated as even, so the LSB is deliberately ignored.
    logic                    w_unused_addr_lsb;
    assign w_unused_addr_lsb = bus.ioctl_addr[0];

    assign w_dl_rise = bus.ioctl_download & ~r_dl_q;
    assign w_strobe  = bus.ioctl_wr & bus.ioctl_download;
    // The buffer can take a new word when empty or when its HI byte leaves now.
    assign w_accept  = w_strobe & (~r_buf_vld_p0 | r_buf_hi_p0);
    assign w_drop    = w_strobe & ~w_accept;

    // A buffered word always has priority; otherwise an incoming word's LO
    // byte goes straight out so a lone word costs no extra cycle.
    assign w_emit      = r_buf_vld_p0 | w_accept;
    assign w_emit_addr = r_buf_vld_p0 ? {r_buf_addr_p0, r_buf_hi_p0}
                                      : {bus.ioctl_addr[ADDR_W-1:1], 1'b0};
    assign w_emit_data = r_buf_vld_p0 ? (r_buf_hi_p0 ? r_buf_data_p0[15:8] : r_buf_data_p0[7:0])
                                      : bus.ioctl_dout[7:0];
    assign w_wr_ok     = w_emit & ~w_oor;

    freeze_rom_region_dec #(
        .MROM1_SIZE (MROM1_SIZE),
        .MROM2_SIZE (MROM2_SIZE),
        .SROM_SIZE  (SROM_SIZE),
        .CHAR_SIZE  (CHAR_SIZE),
        .SPR_SIZE   (SPR_SIZE)
    ) u_dec (
        .i_addr   (w_emit_addr),
        .o_region (w_region),
        .o_offset (w_offset),
        .o_oor    (w_oor)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_load = 1'b0;
        w_check_fail = 1'b0;
        case (r_state)
            IDLE, RUN, ERR: begin
                if (w_dl_rise) begin
                    w_state_nxt  = LOAD;
                    w_enter_load = 1'b1;
                end
            end
            LOAD: begin
                if (w_dl_rise) begin
                    w_enter_load = 1'b1;
                end else if (!r_dl_q && !r_buf_vld_p0) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if ((r_byte_cnt == TOTAL_CNT) && !r_load_err) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt  = ERR;
                    w_check_fail = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A new download clears the count and error in the same cycle that its
    // first byte may already be counted.
    always_comb begin
        w_cnt_nxt = w_enter_load ? '0 : r_byte_cnt;
        if (w_wr_ok) w_cnt_nxt = sat_inc(w_cnt_nxt);
        w_err_nxt = (w_enter_load ? 1'b0 : r_load_err) | (w_emit & w_oor) | w_drop | w_check_fail;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_dl_q        <= 1'b0;
            r_buf_vld_p0  <= 1'b0;
            r_buf_hi_p0   <= 1'b0;
            r_buf_addr_p0 <= '0;
            r_buf_data_p0 <= '0;
            r_rom_we_p1   <= '0;
            r_rom_addr_p1 <= '0;
            r_rom_data_p1 <= '0;
            r_byte_cnt    <= '0;
            r_load_err    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dl_q     <= bus.ioctl_download;
            r_byte_cnt <= w_cnt_nxt;
            r_load_err <= w_err_nxt;

            // ---- stage p0: skid buffer ----
            if (r_buf_vld_p0 && !r_buf_hi_p0) begin
                r_buf_hi_p0 <= 1'b1;
            end else if (w_accept) begin
                r_buf_vld_p0  <= 1'b1;
                r_buf_hi_p0   <= ~r_buf_vld_p0;
                r_buf_addr_p0 <= bus.ioctl_addr[ADDR_W-1:1];
                r_buf_data_p0 <= bus.ioctl_dout;
            end else if (r_buf_vld_p0) begin
                r_buf_vld_p0 <= 1'b0;
            end

            // ---- stage p1: registered byte write ----
            r_rom_we_p1 <= w_wr_ok ? w_region : '0;
            if (w_wr_ok) begin
                r_rom_addr_p1 <= w_offset;
                r_rom_data_p1 <= w_emit_data;
            end
        end
    end

    assign bus.ioctl_wait = r_buf_vld_p0 & ~r_buf_hi_p0;
    assign bus.rom_we     = r_rom_we_p1;
    assign bus.rom_addr   = r_rom_addr_p1;
    assign bus.rom_data   = r_rom_data_p1;
    assign bus.core_reset = (r_state != RUN);
    assign bus.load_err   = r_load_err;

endmodule
